// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the 2-read / 1-write register file: one write port, two read ports.
interface regfile_2r1w_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2
);
  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  modport master (
    output clr, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  clr, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port, two independent read ports,
// per-entry valid flags, optional zero register, write bypass and read register.
module regfile_2r1w #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_REG   = 0
) (
  input logic            clk,
  input logic            rst_n,
  regfile_2r1w_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic              wr_en;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [1:0]        src_valid;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic [1:0]        rvalid_q, rvalid_d;

  assign raddr[0] = bus.raddr_a;
  assign raddr[1] = bus.raddr_b;

  // A write lands only when not clearing and not aimed at a hardwired zero entry.
  assign wr_en = bus.we && !bus.clr && !((ZERO_REG != 0) && (bus.waddr == '0));

  // Next array state: clear dominates, otherwise a single-entry write.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (bus.clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      valid_d = '0;
    end else if (wr_en) begin
      mem_d[bus.waddr]   = bus.wdata;
      valid_d[bus.waddr] = 1'b1;
    end
  end

  // Storage array and valid flags; reset aborts any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  // Per-port read source: zero register, then bypass of this cycle's write, then the array.
  // Bypass is gated by clr so a clearing cycle still shows the pre-clear contents.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      src_data[p]  = mem_q[raddr[p]];
      src_valid[p] = valid_q[raddr[p]];
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        src_data[p]  = '0;
        src_valid[p] = 1'b1;
      end else if ((BYPASS != 0) && bus.we && !bus.clr && (raddr[p] == bus.waddr)) begin
        src_data[p]  = bus.wdata;
        src_valid[p] = 1'b1;
      end
    end
  end

  // Registered-read capture value: a clearing cycle captures an empty entry.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata_d[p]  = src_data[p];
      rvalid_d[p] = src_valid[p];
      if (bus.clr && !((ZERO_REG != 0) && (raddr[p] == '0))) begin
        rdata_d[p]  = '0;
        rvalid_d[p] = 1'b0;
      end
    end
  end

  // Read output register, used only when registered reads are selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      rvalid_q   <= '0;
    end else begin
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.rdata_a  = (RD_REG != 0) ? rdata_q[0]  : src_data[0];
  assign bus.rvalid_a = (RD_REG != 0) ? rvalid_q[0] : src_valid[0];
  assign bus.rdata_b  = (RD_REG != 0) ? rdata_q[1]  : src_data[1];
  assign bus.rvalid_b = (RD_REG != 0) ? rvalid_q[1] : src_valid[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: four configurations share one stimulus stream; expectations
// are queued with the cycle in which they must be visible and checked on negedge.
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(2)) if0 ();
  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(2)) if1 ();
  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(2)) if2 ();
  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(2)) if3 ();

  // u0 defaults, u1 no bypass, u2 registered read, u3 zero register
  regfile_2r1w #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1), .RD_REG(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_2r1w #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0), .RD_REG(0))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  regfile_2r1w #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1), .RD_REG(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  regfile_2r1w #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1), .RD_REG(0))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    int          dut;
    int          due;
    string       name;
    logic [15:0] da;
    logic        va;
    logic [15:0] db;
    logic        vb;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [1:0] wa,
                       input logic [15:0] wd, input logic [1:0] ra, input logic [1:0] rb);
    if0.clr = c; if0.we = w; if0.waddr = wa; if0.wdata = wd; if0.raddr_a = ra; if0.raddr_b = rb;
    if1.clr = c; if1.we = w; if1.waddr = wa; if1.wdata = wd; if1.raddr_a = ra; if1.raddr_b = rb;
    if2.clr = c; if2.we = w; if2.waddr = wa; if2.wdata = wd; if2.raddr_a = ra; if2.raddr_b = rb;
    if3.clr = c; if3.we = w; if3.waddr = wa; if3.wdata = wd; if3.raddr_a = ra; if3.raddr_b = rb;
  endtask

  task automatic expect_rd(input int dut, input int due, input string name,
                           input logic [15:0] da, input logic va,
                           input logic [15:0] db, input logic vb);
    exp_t e;
    e.dut = dut; e.due = due; e.name = name;
    e.da = da; e.va = va; e.db = db; e.vb = vb;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    int          i;
    logic [15:0] ada, adb;
    logic        ava, avb;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].dut)
          0:       begin ada = if0.rdata_a; ava = if0.rvalid_a; adb = if0.rdata_b; avb = if0.rvalid_b; end
          1:       begin ada = if1.rdata_a; ava = if1.rvalid_a; adb = if1.rdata_b; avb = if1.rvalid_b; end
          2:       begin ada = if2.rdata_a; ava = if2.rvalid_a; adb = if2.rdata_b; avb = if2.rvalid_b; end
          default: begin ada = if3.rdata_a; ava = if3.rvalid_a; adb = if3.rdata_b; avb = if3.rvalid_b; end
        endcase
        chk_cnt++;
        if (sb[i].due == cyc && ada === sb[i].da && ava === sb[i].va &&
            adb === sb[i].db && avb === sb[i].vb) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s (u%0d cyc %0d due %0d): got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b",
                   sb[i].name, sb[i].dut, cyc, sb[i].due, ada, ava, adb, avb,
                   sb[i].da, sb[i].va, sb[i].db, sb[i].vb);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0);

    // Reset state, with zero register reading valid even in reset
    step();
    expect_rd(0, cyc, "reset_u0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(1, cyc, "reset_u1", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(2, cyc, "reset_u2", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(3, cyc, "reset_u3_zero", 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Write A5A5 to addr 2, read back next cycle
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2'd2, 16'hA5A5, 2'd0, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 2'd3);
    expect_rd(0, cyc,     "basic_u0", 16'hA5A5, 1'b1, 16'h0000, 1'b0);
    expect_rd(1, cyc,     "basic_u1", 16'hA5A5, 1'b1, 16'h0000, 1'b0);
    expect_rd(3, cyc,     "basic_u3", 16'hA5A5, 1'b1, 16'h0000, 1'b0);
    expect_rd(2, cyc + 1, "basic_u2_reg", 16'hA5A5, 1'b1, 16'h0000, 1'b0);

    // Same-cycle write/read of addr 1
    step();
    drive(1'b0, 1'b1, 2'd1, 16'h1234, 2'd1, 2'd2);
    expect_rd(0, cyc,     "bypass_u0", 16'h1234, 1'b1, 16'hA5A5, 1'b1);
    expect_rd(1, cyc,     "nobypass_u1", 16'h0000, 1'b0, 16'hA5A5, 1'b1);
    expect_rd(3, cyc,     "bypass_u3", 16'h1234, 1'b1, 16'hA5A5, 1'b1);
    expect_rd(2, cyc + 1, "bypass_u2_reg", 16'h1234, 1'b1, 16'hA5A5, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd1);
    expect_rd(0, cyc, "same_addr_u0", 16'h1234, 1'b1, 16'h1234, 1'b1);
    expect_rd(1, cyc, "same_addr_u1", 16'h1234, 1'b1, 16'h1234, 1'b1);

    // Registered-read latency: 00FF to addr 3, then raddr_b=3
    step();
    drive(1'b0, 1'b1, 2'd3, 16'h00FF, 2'd0, 2'd0);
    expect_rd(2, cyc, "reg_prev_u2", 16'h1234, 1'b1, 16'h1234, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3);
    expect_rd(2, cyc,     "reg_not_before_u2", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(2, cyc + 1, "reg_latency_u2", 16'h0000, 1'b0, 16'h00FF, 1'b1);

    // Zero register ignores writes to addr 0
    step();
    drive(1'b0, 1'b1, 2'd0, 16'hFFFF, 2'd0, 2'd3);
    expect_rd(3, cyc, "zero_wr_u3", 16'h0000, 1'b1, 16'h00FF, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd2);
    expect_rd(3, cyc, "zero_after_u3", 16'h0000, 1'b1, 16'hA5A5, 1'b1);
    expect_rd(0, cyc, "addr0_u0", 16'hFFFF, 1'b1, 16'hA5A5, 1'b1);

    // Clear with a simultaneous write
    step();
    drive(1'b1, 1'b1, 2'd1, 16'hBEEF, 2'd1, 2'd2);
    expect_rd(0, cyc,     "clr_preclear_u0", 16'h1234, 1'b1, 16'hA5A5, 1'b1);
    expect_rd(2, cyc + 1, "clr_reg_u2", 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd3);
    expect_rd(0, cyc, "clr_after_u0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(3, cyc, "clr_after_u3", 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd2);
    expect_rd(0, cyc, "clr_addr0_u0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(3, cyc, "clr_zero_u3", 16'h0000, 1'b1, 16'h0000, 1'b0);

    // Fill entries with 1..4, then asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b0, 1'b1, 2'(i), 16'(i + 1), 2'd0, 2'd0);
    end
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3);
    expect_rd(0, cyc, "fill_u0", 16'h0001, 1'b1, 16'h0004, 1'b1);
    expect_rd(2, cyc, "fill_u2", 16'h0001, 1'b1, 16'h0001, 1'b1);
    step();
    drive(1'b0, 1'b1, 2'd3, 16'h7777, 2'd1, 2'd2);
    #1 rst_n = 1'b0;
    expect_rd(0, cyc, "async_rst_u0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(1, cyc, "async_rst_u1", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(2, cyc, "async_rst_u2", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(3, cyc, "async_rst_u3", 16'h0000, 1'b0, 16'h0000, 1'b0);
    #1;
    chk_cnt++;
    if (if0.rdata_a === 16'h0000 && if0.rvalid_a === 1'b0 &&
        if0.rdata_b === 16'h0000 && if0.rvalid_b === 1'b0) pass_cnt++;
    else $display("FAIL direct_async_rst_u0: a=%h/%b b=%h/%b",
                  if0.rdata_a, if0.rvalid_a, if0.rdata_b, if0.rvalid_b);
    chk_cnt++;
    if (if1.rdata_a === 16'h0000 && if1.rvalid_a === 1'b0 &&
        if1.rdata_b === 16'h0000 && if1.rvalid_b === 1'b0) pass_cnt++;
    else $display("FAIL direct_async_rst_u1: a=%h/%b b=%h/%b",
                  if1.rdata_a, if1.rvalid_a, if1.rdata_b, if1.rvalid_b);
    chk_cnt++;
    if (if2.rdata_a === 16'h0000 && if2.rvalid_a === 1'b0 &&
        if2.rdata_b === 16'h0000 && if2.rvalid_b === 1'b0) pass_cnt++;
    else $display("FAIL direct_async_rst_u2: a=%h/%b b=%h/%b",
                  if2.rdata_a, if2.rvalid_a, if2.rdata_b, if2.rvalid_b);
    chk_cnt++;
    if (if3.rdata_a === 16'h0000 && if3.rvalid_a === 1'b0 &&
        if3.rdata_b === 16'h0000 && if3.rvalid_b === 1'b0) pass_cnt++;
    else $display("FAIL direct_async_rst_u3: a=%h/%b b=%h/%b",
                  if3.rdata_a, if3.rvalid_a, if3.rdata_b, if3.rvalid_b);
    step();
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd3);
    rst_n = 1'b1;
    expect_rd(0, cyc,     "post_rst_u0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    expect_rd(2, cyc + 1, "post_rst_u2", 16'h0000, 1'b0, 16'h0000, 1'b0);

    step();
    step();
    step();
    // Anything still queued was never presented in its cycle.
    while (sb.size() > 0) begin
      chk_cnt++;
      $display("FAIL %s (u%0d): expectation due %0d never checked", sb[0].name, sb[0].dut, sb[0].due);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    if (pass_cnt == chk_cnt) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file; successor to the fixed 4x16 single-read-port store.
- One write port and two independent read ports, sized so a datapath can read two source operands per cycle.
- Configurable width and depth, optional hardwired-zero register, optional write-to-read bypass, optional registered read outputs.
- Per-entry valid flags track which entries have been written since reset or clear.

Parameters:
- DATA_W, 16, data width in bits (>=1).
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, 1 = entry 0 hardwired to zero.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wdata.
- RD_REG, 0, 0 = combinational read (latency 0); 1 = registered read (latency 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear of all entries and valid flags.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read port A address.
- rdata_a  out  DATA_W  read port A data.
- rvalid_a  out  1  entry A has been written since the last reset or clear.
- raddr_b  in  ADDR_W  read port B address.
- rdata_b  out  DATA_W  read port B data.
- rvalid_b  out  1  entry B has been written since the last reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous): every entry = 0 and every valid flag = 0.
  - RD_REG=1: rdata_a/b = 0 and rvalid_a/b = 0 while reset is asserted.
  - RD_REG=0: outputs reflect the cleared array, so rdata = 0 and rvalid = 0.
  - Reset asserted mid-write aborts that write; deassertion takes effect at the next rising edge.
- Write, on the clock edge when we=1 and clr=0:
  - mem[waddr] <= wdata and valid[waddr] <= 1.
  - Entries not addressed hold their value.
- Clear, on the clock edge when clr=1:
  - All entries <= 0 and all valid flags <= 0.
  - clr wins over a simultaneous we; that write is dropped.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return data 0 with valid = 1, regardless of reset or clear.
- Read with RD_REG=0:
  - rdata_x = mem[raddr_x] and rvalid_x = valid[raddr_x], combinationally.
- Read with RD_REG=1:
  - rdata_x and rvalid_x are captured at the clock edge from the same source, so the read value appears one cycle after raddr_x.
- Bypass (BYPASS=1), when we=1, clr=0, raddr_x == waddr, and the address is not zero-hardwired:
  - The read source is wdata with valid = 1 instead of the stored entry.
  - RD_REG=0: bypass is combinational in the same cycle.
  - RD_REG=1: the registered output captures wdata.
- BYPASS=0: a same-cycle read returns the old entry value.
- clr=1 in the same cycle as a read:
  - RD_REG=0 with BYPASS=1: the read returns the pre-clear entry and bypass is suppressed.
  - RD_REG=1: the registered output captures 0 with valid = 0.
- Ports A and B are fully independent; the same address on both ports returns identical data.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.

Test Plan:
- Defaults: reset, then write 16'hA5A5 to addr 2; next cycle read A=2, B=3 -> rdata_a=A5A5, rvalid_a=1, rdata_b=0, rvalid_b=0.
- BYPASS=1, RD_REG=0: same cycle we=1, waddr=1, wdata=16'h1234, raddr_a=1 -> rdata_a=1234 and rvalid_a=1 in that cycle. With BYPASS=0 -> rdata_a=old value (0).
- RD_REG=1: write 16'h00FF to addr 3, then set raddr_b=3 -> rdata_b=00FF exactly one edge later and not before. Bypass case: registered output=wdata at the next edge.
- ZERO_REG=1: write 16'hFFFF to addr 0 -> read addr 0 gives 0 with valid=1; other entries unchanged.
- clr=1 together with we=1 (addr 1, 16'hBEEF) -> after the edge all entries=0 and all valid=0; addr 1 reads 0.
- Fill all 4 entries with 1,2,3,4; assert rst_n low mid-cycle -> outputs go to 0/valid 0 immediately without a clock edge. After release, the array still reads 0.
